boa_mem_arbiter: RTL

- Two-requester arbiter that shares one downstream boa_mem_bus (the MMIO peripheral bus) between two upstream masters, e.g. CPU data port and a DMA/debug port.
- Selects one requester per access, forwards its request downstream and routes ready/rdata back.
- Downstream peripherals return rdata registered, one cycle after the accepting edge; the arbiter tracks ownership so each read result reaches the requester that issued it.

---
 rtl/boa_mem_arbiter_if.sv | 15 +
 rtl/boa_mem_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/boa_mem_arbiter_if.sv
// boa_mem_bus: MMIO peripheral bus. The MEM side is the peripheral/slave view, the CPU side is the master view.
// rdata is registered by the peripheral and is valid one cycle after the accepting edge.
interface boa_mem_bus #(
    parameter int alen = 32
);
    logic            re;
    logic [3:0]      we;
    logic [alen-1:2] addr;
    logic [31:0]     wdata;
    logic            ready;
    logic [31:0]     rdata;

    modport MEM (input re, we, addr, wdata, output ready, rdata);
    modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_mem_arbiter.sv
// Two-requester arbiter for one downstream boa_mem_bus, with round-robin or fixed priority and optional grant hold.
// Latency: zero cycles on request and on ready; rdata is routed one cycle after accept, exactly as on a direct connection.
// Backpressure: downstream ready is passed only to the granted requester; the other requester sees ready=0 and holds.
module boa_mem_arbiter #(
    parameter bit fixed_prio = 1'b0,
    parameter bit hold_grant = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    boa_mem_bus.MEM req0,
    boa_mem_bus.MEM req1,
    boa_mem_bus.CPU mem,
    output logic   owner,
    output logic   busy
);
    localparam int W_AW0 = $bits(req0.addr);
    localparam int W_AW1 = $bits(req1.addr);
    localparam int W_AWM = $bits(mem.addr);

    generate
        if ((W_AW0 != W_AWM) || (W_AW1 != W_AWM)) begin : g_alen_mismatch
            $error("boa_mem_arbiter: all ports must share one alen");
        end
    endgenerate

    logic w_act0;
    logic w_act1;
    logic w_hold_eff;
    logic w_gnt;
    logic w_busy;
    logic w_acc;
    logic w_rd_live;

    logic r_prio_ptr;
    logic r_hold;
    logic r_held_owner;
    logic r_rd_valid;
    logic r_rd_owner;

    assign w_act0 = req0.re | (|req0.we);
    assign w_act1 = req1.re | (|req1.we);

    // A hold only counts while the held requester is still asking; otherwise arbitrate normally this cycle.
    assign w_hold_eff = hold_grant && r_hold && (r_held_owner ? w_act1 : w_act0);

    always_comb begin
        w_gnt = 1'b0;
        if (w_hold_eff) begin
            w_gnt = r_held_owner;
        end else if (w_act0 && w_act1) begin
            w_gnt = fixed_prio ? 1'b0 : r_prio_ptr;
        end else if (w_act1) begin
            w_gnt = 1'b1;
        end
    end

    // Reset dominates the combinational outputs too, so nothing leaks out during the reset cycle.
    assign w_busy    = ~rst & (w_act0 | w_act1);
    assign w_acc     = w_busy & mem.ready;
    assign w_rd_live = ~rst & r_rd_valid;

    assign mem.re    = w_busy & (w_gnt ? req1.re : req0.re);
    assign mem.we    = w_busy ? (w_gnt ? req1.we : req0.we) : 4'h0;
    assign mem.addr  = w_busy ? (w_gnt ? req1.addr : req0.addr) : '0;
    assign mem.wdata = w_busy ? (w_gnt ? req1.wdata : req0.wdata) : 32'h0;

    assign req0.ready = w_busy & ~w_gnt & mem.ready;
    assign req1.ready = w_busy &  w_gnt & mem.ready;

    assign req0.rdata = (w_rd_live & ~r_rd_owner) ? mem.rdata : 32'h0;
    assign req1.rdata = (w_rd_live &  r_rd_owner) ? mem.rdata : 32'h0;

    assign busy  = w_busy;
    assign owner = w_busy & w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_ptr   <= 1'b0;
            r_hold       <= 1'b0;
            r_held_owner <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_valid <= w_acc;
            if (w_acc) begin
                r_rd_owner <= w_gnt;
                if (w_gnt == r_prio_ptr) begin
                    r_prio_ptr <= ~r_prio_ptr;
                end
            end
            if (hold_grant && w_busy && !mem.ready) begin
                r_hold       <= 1'b1;
                r_held_owner <= w_gnt;
            end else begin
                r_hold <= 1'b0;
            end
        end
    end
endmodule
